fifo_video_reader: RTL and testbench

- Read-side consumer for the team's valid/ready pixel FIFOs: pops one word per active-video pixel and emits a timed video stream (de/hs/vs/data).
- Sits in the output clock domain, directly downstream of the FIFO read port.
- Owns raster timing, start-up alignment and underflow reporting.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_gen.sv | 53 +++++
 rtl/fifo_video_reader.sv | 109 ++++++++++
 tb/tb_fifo_video_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster-timing helpers for the output-side video blocks:
// total/width calculations, reader FSM encodings and the sync-window decode.
package video_timing_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // A one-count raster still needs a 1-bit counter.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(1920, 88, 44, 148);
  localparam int DEF_V_TOTAL = timing_total(1080, 4, 5, 36);
  localparam int DEF_HCNT_W  = cnt_width(DEF_H_TOTAL);
  localparam int DEF_VCNT_W  = cnt_width(DEF_V_TOTAL);

  function automatic logic in_window(input logic [31:0] cnt, input logic [31:0] lo,
                                     input logic [31:0] len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running hcnt/vcnt raster generator with active/hsync/vsync decode.
// Counters sit at the frame origin while disabled.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic active,
  output logic hs,
  output logic vs,
  output logic sof
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] hcnt_r;
  logic [VW-1:0] vcnt_r;

  // Raster counters: vcnt steps on every hcnt wrap.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hcnt_r <= '0;
      vcnt_r <= '0;
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= '0;
      vcnt_r <= (vcnt_r == V_LAST) ? '0 : vcnt_r + 1'b1;
    end else begin
      hcnt_r <= hcnt_r + 1'b1;
    end
  end

  assign active = en && (hcnt_r < HW'(H_ACTIVE)) && (vcnt_r < VW'(V_ACTIVE));
  assign hs     = en && in_window(32'(hcnt_r), 32'(H_ACTIVE + H_FP), 32'(H_SYNC));
  assign vs     = en && in_window(32'(vcnt_r), 32'(V_ACTIVE + V_FP), 32'(V_SYNC));
  assign sof    = active && (hcnt_r == '0) && (vcnt_r == '0);

endmodule

// File: rtl/fifo_video_reader.sv
// Read-side FIFO consumer: pops one word per active pixel and emits a
// registered de/hs/vs/data stream with sticky underflow reporting.
module fifo_video_reader
  import video_timing_pkg::*;
#(
  parameter int DW       = 24,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rval_i,
  input  logic [DW-1:0] rdata_i,
  output logic          rrdy_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic [DW-1:0] data_o,
  output logic          underflow_o,
  output logic          frame_start_o
);

  logic [0:0]    state_r;
  logic          run_s;
  logic          active_s;
  logic          hs_s;
  logic          vs_s;
  logic          sof_s;
  logic          pop_s;
  logic          starve_s;
  logic          de_r;
  logic          hs_r;
  logic          vs_r;
  logic [DW-1:0] data_r;
  logic          underflow_r;
  logic          frame_start_r;

  assign run_s = (state_r == RUN);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (run_s),
    .active (active_s),
    .hs     (hs_s),
    .vs     (vs_s),
    .sof    (sof_s)
  );

  // Pop request depends only on raster position, never on rval_i.
  assign rrdy_o   = active_s;
  assign pop_s    = active_s && rval_i;
  assign starve_s = active_s && !rval_i;

  // Start-up alignment: the first valid word opens the raster; only reset returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= rval_i ? RUN : IDLE;
        RUN:     state_r <= RUN;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output register, one cycle behind the counters; a starved pixel goes out as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_r          <= 1'b0;
      hs_r          <= 1'b0;
      vs_r          <= 1'b0;
      data_r        <= '0;
      underflow_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      de_r          <= active_s;
      hs_r          <= hs_s;
      vs_r          <= vs_s;
      data_r        <= pop_s ? rdata_i : '0;
      underflow_r   <= underflow_r | starve_s;
      frame_start_r <= sof_s;
    end
  end

  assign de_o          = de_r;
  assign hs_o          = hs_r;
  assign vs_o          = vs_r;
  assign data_o        = data_r;
  assign underflow_o   = underflow_r;
  assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_fifo_video_reader.sv
// Directed bench for fifo_video_reader on an 8x6 raster (4x3 active) fed
// from a queue-based FIFO model.
module tb_fifo_video_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rval;
  logic [DW-1:0] rdata;
  logic          rrdy;
  logic          de;
  logic          hs;
  logic          vs;
  logic [DW-1:0] data;
  logic          uf;
  logic          fs;

  always #5 clk = ~clk;

  fifo_video_reader #(
    .DW(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rval_i        (rval),
    .rdata_i       (rdata),
    .rrdy_o        (rrdy),
    .de_o          (de),
    .hs_o          (hs),
    .vs_o          (vs),
    .data_o        (data),
    .underflow_o   (uf),
    .frame_start_o (fs)
  );

  logic [DW-1:0] fifo[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  int   drop_at;
  int   pops;
  logic src_en;
  logic model_on;
  logic exp_uf;

  // Raster position of cycle c counted from the first RUN cycle.
  function automatic logic act_at(input int c);
    int h;
    int v;
    h = c % 8;
    v = (c / 8) % 6;
    return (h < 4) && (v < 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rval  = src_en && (fifo.size() > 0) && (cyc != drop_at);
    rdata = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic tick();
    logic          pop_now;
    logic          p_act;
    logic          p_rval;
    logic [DW-1:0] p_rdata;
    int            h;
    int            v;
    pop_now = rval && rrdy;
    p_act   = act_at(cyc);
    p_rval  = rval;
    p_rdata = rdata;
    h = cyc % 8;
    v = (cyc / 8) % 6;
    @(posedge clk);
    #1;
    if (pop_now) begin
      fifo.delete(0);
      pops++;
    end
    cyc++;
    drive();
    if (model_on) begin
      exp_uf = exp_uf | (p_act && !p_rval);
      check("de", de, p_act);
      check("hs", hs, (h >= 5) && (h < 7));
      check("vs", vs, v == 4);
      check("data", data, (p_act && p_rval) ? p_rdata : 8'h00);
      check("frame_start", fs, p_act && (h == 0) && (v == 0));
      check("underflow", uf, exp_uf);
      check("rrdy", rrdy, act_at(cyc));
    end
  endtask

  initial begin
    int k;
    int rdy_cnt;
    int fs_cnt;
    int fs_cyc;
    int hs_cnt;
    int vs_cnt;
    int occ;

    rst = 1'b1; rval = 1'b0; rdata = 8'h00;
    src_en = 1'b0; model_on = 1'b0; drop_at = -100; cyc = 0; exp_uf = 1'b0; pops = 0;

    // 1: reset then idle with no data
    repeat (3) tick();
    check("rst_outputs", {rrdy, de, hs, vs, fs, uf, data}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", {rrdy, de, hs, vs, fs, uf, data}, 32'h0);
    end

    // 2: one frame from a 12-word FIFO
    for (int i = 1; i <= 12; i++) fifo.push_back(8'(i));
    src_en = 1'b1;
    drive();
    check("idle_rval_rrdy", rrdy, 1'b0);
    cyc = -1;
    tick();
    check("first_run_rrdy", rrdy, 1'b1);
    check("first_run_de", de, 1'b0);
    model_on = 1'b1;
    pops = 0; k = 0; rdy_cnt = 0; fs_cnt = 0; fs_cyc = -1;
    for (int i = 0; i < 48; i++) begin
      if (rrdy) rdy_cnt++;
      tick();
      if (fs) begin
        fs_cnt++;
        fs_cyc = cyc;
      end
      if (de) begin
        check("frame1_order", data, 8'(k + 1));
        k++;
      end
    end
    check("frame1_pops", pops, 12);
    check("frame1_rrdy_cycles", rdy_cnt, 12);
    check("frame1_pixels", k, 12);
    check("frame1_fs_count", fs_cnt, 1);
    check("frame1_fs_cycle", fs_cyc, 1);

    // 3: two frames with a full FIFO
    for (int i = 0; i < 48; i++) fifo.push_back(8'(8'h20 + i));
    drive();
    for (int f = 0; f < 2; f++) begin
      pops = 0; hs_cnt = 0; vs_cnt = 0;
      repeat (48) begin
        tick();
        if (hs) hs_cnt++;
        if (vs) vs_cnt++;
      end
      check("full_pops", pops, 12);
      check("full_hs_cycles", hs_cnt, 12);
      check("full_vs_cycles", vs_cnt, 8);
      check("full_no_underflow", uf, 1'b0);
    end

    // 4: valid dropped on the third pixel of line 1 (cycle 154)
    drop_at = 154;
    repeat (11) tick();
    check("drop_de", de, 1'b1);
    check("drop_data_zero", data, 8'h00);
    check("drop_underflow", uf, 1'b1);
    tick();
    check("drop_word_kept", data, 8'h3E);
    check("drop_underflow_sticky", uf, 1'b1);

    // 5: reset at hcnt=2, vcnt=1 with rval held high
    repeat (202 - 156) tick();
    check("pre_reset_rrdy", rrdy, 1'b1);
    rst = 1'b1;
    model_on = 1'b0;
    tick();
    check("mid_reset_outputs", {rrdy, de, hs, vs, fs, uf, data}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) fifo.push_back(8'(8'h60 + i));
    drive();
    cyc = -1;
    exp_uf = 1'b0;
    tick();
    check("restart_rrdy", rrdy, 1'b1);
    check("restart_underflow", uf, 1'b0);
    model_on = 1'b1;
    tick();
    check("restart_fs", fs, 1'b1);

    // 6: words waiting through horizontal blanking are not consumed
    repeat (3) tick();
    occ = fifo.size();
    check("blank_rval", rval, 1'b1);
    repeat (4) tick();
    check("blank_occupancy", fifo.size(), occ);
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
